// File: rtl/fsm_stimulus_serializer.sv
// Parallel-to-serial stimulus feeder for the Moore FSM stage: accepts a word over
// valid/ready, shifts it out one bit per clock on x, then idles for a fixed gap.
module fsm_stimulus_serializer #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 2,
    parameter int IDLE_LEVEL = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic                     x,
    output logic                     x_valid,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic                     word_done,
    output logic                     busy,
    output logic [1:0]               state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_GAP   = 2'b10,
        S_BAD   = 2'b11
    } state_e;

    localparam int IW = $clog2(WIDTH);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic IDLE_X = (IDLE_LEVEL != 0);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IW-1:0]    bit_idx_q, bit_idx_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             word_done_q, word_done_d;

    // The shift register always holds the bit currently on x at its lead end.
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_idx_d   = bit_idx_q;
        gap_cnt_d   = gap_cnt_q;
        x_d         = IDLE_X;
        x_valid_d   = 1'b0;
        word_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    state_d   = S_SHIFT;
                    shreg_d   = din;
                    x_d       = lead_bit(din);
                    x_valid_d = 1'b1;
                    bit_idx_d = '0;
                end
            end
            S_SHIFT: begin
                if (bit_idx_q == IDX_LAST) begin
                    state_d     = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                    shreg_d     = '0;
                    bit_idx_d   = '0;
                    gap_cnt_d   = '0;
                    word_done_d = 1'b1;
                end else begin
                    shreg_d   = advance(shreg_q);
                    x_d       = lead_bit(advance(shreg_q));
                    x_valid_d = 1'b1;
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = S_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                shreg_d   = '0;
                bit_idx_d = '0;
                gap_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            bit_idx_q   <= '0;
            gap_cnt_q   <= '0;
            x_q         <= IDLE_X;
            x_valid_q   <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_idx_q   <= bit_idx_d;
            gap_cnt_q   <= gap_cnt_d;
            x_q         <= x_d;
            x_valid_q   <= x_valid_d;
            word_done_q <= word_done_d;
        end
    end

    assign din_ready = (state_q == S_IDLE) && !reset;
    assign x         = x_q;
    assign x_valid   = x_valid_q;
    assign bit_idx   = bit_idx_q;
    assign word_done = word_done_q;
    assign busy      = (state_q != S_IDLE);
    assign state     = state_q;

endmodule
